// File: rtl/edge_overlay_pkg.sv
// Shared types and defaults for the edge-overlay output stage.
package edge_overlay_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned EDGE_W = 8;

  localparam int unsigned       DEFAULT_WIDTH     = 720;
  localparam int unsigned       DEFAULT_HEIGHT    = 540;
  localparam logic [PIX_W-1:0]  DEFAULT_HIGHLIGHT = 24'hFF0000;

  // Counter width for a dimension; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_overlay_pixel.sv
// Combinational per-pixel decision: highlight interior pixels whose edge exceeds the threshold.
module edge_overlay_pixel
  import edge_overlay_pkg::*;
#(
  parameter int unsigned      WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned      HEIGHT          = DEFAULT_HEIGHT,
  parameter int unsigned      EDGE_THRESHOLD  = 0,
  parameter logic [PIX_W-1:0] HIGHLIGHT_COLOR = DEFAULT_HIGHLIGHT,
  parameter int unsigned      COL_W           = cnt_w(DEFAULT_WIDTH),
  parameter int unsigned      ROW_W           = cnt_w(DEFAULT_HEIGHT)
) (
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [PIX_W-1:0]  img_i,
  input  logic [EDGE_W-1:0] edge_i,
  output logic [PIX_W-1:0]  pix_o
);

  logic border_c;
  logic over_c;

  always_comb begin
    border_c = (row_i == '0) || (row_i == ROW_W'(HEIGHT - 1)) ||
               (col_i == '0) || (col_i == COL_W'(WIDTH - 1));
    over_c   = 32'(edge_i) > EDGE_THRESHOLD;
    pix_o    = (over_c && !border_c) ? HIGHLIGHT_COLOR : img_i;
  end

endmodule

// File: rtl/edge_overlay_tx.sv
// Pops aligned image/edge FIFOs, overlays highlight colour on edges, pushes to output FIFO.
module edge_overlay_tx
  import edge_overlay_pkg::*;
#(
  parameter int unsigned      WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned      HEIGHT          = DEFAULT_HEIGHT,
  parameter int unsigned      EDGE_THRESHOLD  = 0,
  parameter logic [PIX_W-1:0] HIGHLIGHT_COLOR = DEFAULT_HIGHLIGHT
) (
  input  logic              clock,
  input  logic              reset,
  output logic              img_rd_en,
  input  logic              img_empty,
  input  logic [PIX_W-1:0]  img_dout,
  output logic              edge_rd_en,
  input  logic              edge_empty,
  input  logic [EDGE_W-1:0] edge_dout,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic [PIX_W-1:0]  out_din,
  output logic              frame_done
);

  localparam int unsigned COL_W = cnt_w(WIDTH);
  localparam int unsigned ROW_W = cnt_w(HEIGHT);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [PIX_W-1:0]   pix_c;
  logic               last_c;

  edge_overlay_pixel #(
    .WIDTH           (WIDTH),
    .HEIGHT          (HEIGHT),
    .EDGE_THRESHOLD  (EDGE_THRESHOLD),
    .HIGHLIGHT_COLOR (HIGHLIGHT_COLOR),
    .COL_W           (COL_W),
    .ROW_W           (ROW_W)
  ) u_pixel (
    .row_i  (row_q),
    .col_i  (col_q),
    .img_i  (img_dout),
    .edge_i (edge_dout),
    .pix_o  (pix_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      col_q   <= '0;
      row_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
    end
  end

  // Pops and pushes are strobes within the current cycle, so they decode the state directly.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pix_d      = pix_q;
    img_rd_en  = 1'b0;
    edge_rd_en = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    frame_done = 1'b0;
    last_c     = (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));

    case (state_q)
      FETCH: begin
        if (!img_empty && !edge_empty && !reset) begin
          img_rd_en  = 1'b1;
          edge_rd_en = 1'b1;
          pix_d      = pix_c;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        out_din = pix_q;
        if (!out_full) begin
          out_wr_en = 1'b1;
          if (last_c) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            if (col_q == COL_W'(WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        col_d      = '0;
        row_d      = '0;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_edge_overlay_tx.sv
// Directed bench for edge_overlay_tx with a 4x3 frame at thresholds 0 and 8.
module tb_edge_overlay_tx;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        img_rd_en, img_empty, edge_rd_en, edge_empty;
  logic        out_wr_en, out_full, frame_done;
  logic [23:0] img_dout, out_din;
  logic [7:0]  edge_dout;

  logic        img_rd_en8, img_empty8, edge_rd_en8, edge_empty8;
  logic        out_wr_en8, out_full8, frame_done8;
  logic [23:0] img_dout8, out_din8;
  logic [7:0]  edge_dout8;

  edge_overlay_tx #(.WIDTH(4), .HEIGHT(3), .EDGE_THRESHOLD(0), .HIGHLIGHT_COLOR(24'hFF0000)) dut (
    .clock(clock), .reset(reset),
    .img_rd_en(img_rd_en), .img_empty(img_empty), .img_dout(img_dout),
    .edge_rd_en(edge_rd_en), .edge_empty(edge_empty), .edge_dout(edge_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .frame_done(frame_done));

  edge_overlay_tx #(.WIDTH(4), .HEIGHT(3), .EDGE_THRESHOLD(8), .HIGHLIGHT_COLOR(24'hFF0000)) dut8 (
    .clock(clock), .reset(reset),
    .img_rd_en(img_rd_en8), .img_empty(img_empty8), .img_dout(img_dout8),
    .edge_rd_en(edge_rd_en8), .edge_empty(edge_empty8), .edge_dout(edge_dout8),
    .out_wr_en(out_wr_en8), .out_full(out_full8), .out_din(out_din8), .frame_done(frame_done8));

  logic [23:0] img_q[$];
  logic [7:0]  edge_q[$];
  logic [23:0] cap[$];
  logic [7:0]  edge8_q[$];
  logic [23:0] cap8[$];
  int          img_pops, misaligned, fd_cnt, fd8_cnt;
  logic        pend_img, pend_edge, pend8;
  int          n_cmp, n_bad;

  function automatic void refresh();
    img_empty   = (img_q.size() == 0);
    img_dout    = img_empty ? 24'h0 : img_q[0];
    edge_empty  = (edge_q.size() == 0);
    edge_dout   = edge_empty ? 8'h0 : edge_q[0];
    img_empty8  = (edge8_q.size() == 0);
    edge_empty8 = img_empty8;
    img_dout8   = 24'h102030;
    edge_dout8  = img_empty8 ? 8'h0 : edge8_q[0];
  endfunction

  // FIFO/out-FIFO models: sample strobes at negedge, apply pops just after posedge.
  always @(negedge clock) begin
    pend_img  = img_rd_en;
    pend_edge = edge_rd_en;
    pend8     = img_rd_en8;
    if (img_rd_en) img_pops++;
    if (img_rd_en != edge_rd_en) misaligned++;
    if (img_rd_en8 != edge_rd_en8) misaligned++;
    if (out_wr_en) cap.push_back(out_din);
    if (out_wr_en8) cap8.push_back(out_din8);
    if (frame_done) fd_cnt++;
    if (frame_done8) fd8_cnt++;
  end

  always @(posedge clock) begin
    #1;
    if (pend_img && img_q.size() > 0) void'(img_q.pop_front());
    if (pend_edge && edge_q.size() > 0) void'(edge_q.pop_front());
    if (pend8 && edge8_q.size() > 0) void'(edge8_q.pop_front());
    pend_img = 1'b0; pend_edge = 1'b0; pend8 = 1'b0;
    refresh();
  end

  function automatic logic [23:0] exp_pix(input int idx, input logic [23:0] img,
                                          input logic [7:0] e, input int th);
    int r, c;
    r = (idx % 12) / 4;
    c = idx % 4;
    if (r == 1 && c >= 1 && c <= 2 && int'(e) > th) return 24'hFF0000;
    return img;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push_pair(input logic [23:0] p, input logic [7:0] e);
    img_q.push_back(p);
    edge_q.push_back(e);
    refresh();
  endtask

  task automatic clear_obs();
    cap.delete();
    cap8.delete();
    img_pops = 0;
    fd_cnt   = 0;
    fd8_cnt  = 0;
  endtask

  task automatic wait_cap(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (cap.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_cmp++;
    if (cap.size() < n) begin
      n_bad++;
      $display("FAIL %s timeout: writes=%0d required=%0d", name, cap.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_full = 1'b0;
    out_full8 = 1'b0;
    refresh();
    #12;
    n_cmp++; if (img_rd_en !== 1'b0)  begin n_bad++; $display("FAIL reset_img_rd_en got=%b exp=0", img_rd_en); end
    n_cmp++; if (edge_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_edge_rd_en got=%b exp=0", edge_rd_en); end
    n_cmp++; if (out_wr_en !== 1'b0)  begin n_bad++; $display("FAIL reset_out_wr_en got=%b exp=0", out_wr_en); end
    n_cmp++; if (out_din !== 24'h0)   begin n_bad++; $display("FAIL reset_out_din got=%h exp=000000", out_din); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    step(1);
    reset = 1'b0;
    step(1);
    clear_obs();
  endtask

  task automatic test_frame();
    for (int i = 0; i < 12; i++) push_pair(24'h102030, 8'h05);
    wait_cap(12, 60, "frame_writes");
    step(3);
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp_pix(i, 24'h102030, 8'h05, 0)) begin
        n_bad++; $display("FAIL frame_pix[%0d] got=%h exp=%h", i, cap[i], exp_pix(i, 24'h102030, 8'h05, 0));
      end
    end
    n_cmp++; if (fd_cnt !== 1)     begin n_bad++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
    n_cmp++; if (cap.size() !== 12) begin n_bad++; $display("FAIL frame_write_count got=%0d exp=12", cap.size()); end
    clear_obs();
  endtask

  task automatic test_starve();
    img_q.push_back(24'hABCDEF);
    refresh();
    step(10);
    n_cmp++; if (img_pops !== 0)   begin n_bad++; $display("FAIL starve_pops got=%0d exp=0", img_pops); end
    n_cmp++; if (cap.size() !== 0) begin n_bad++; $display("FAIL starve_writes got=%0d exp=0", cap.size()); end
  endtask

  task automatic test_stall();
    int k;
    out_full = 1'b1;
    edge_q.push_back(8'h05);
    refresh();
    k = 0;
    while (img_pops < 1 && k < 20) begin @(negedge clock); k++; end
    step(1);
    push_pair(24'h111111, 8'h05);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_cmp++; if (out_wr_en !== 1'b0)   begin n_bad++; $display("FAIL stall_wr_en[%0d] got=%b exp=0", i, out_wr_en); end
      n_cmp++; if (out_din !== 24'hABCDEF) begin n_bad++; $display("FAIL stall_din[%0d] got=%h exp=abcdef", i, out_din); end
      n_cmp++; if (img_pops !== 1)       begin n_bad++; $display("FAIL stall_pops[%0d] got=%0d exp=1", i, img_pops); end
      step(1);
    end
    out_full = 1'b0;
    wait_cap(1, 10, "stall_release");
    @(negedge clock);
    n_cmp++; if (cap.size() !== 1) begin n_bad++; $display("FAIL stall_single_write got=%0d exp=1", cap.size()); end
    n_cmp++; if (cap[0] !== 24'hABCDEF) begin n_bad++; $display("FAIL stall_data got=%h exp=abcdef", cap[0]); end
    wait_cap(2, 20, "stall_next");
    n_cmp++; if (cap[1] !== 24'h111111) begin n_bad++; $display("FAIL stall_next_data got=%h exp=111111", cap[1]); end
  endtask

  task automatic test_reset_mid();
    int k;
    for (int i = 0; i < 3; i++) push_pair(24'h222222, 8'h05);
    wait_cap(5, 30, "mid_five");
    step(2);
    out_full = 1'b1;
    push_pair(24'h0000AA, 8'h05);
    k = 0;
    while (img_pops < 6 && k < 20) begin @(negedge clock); k++; end
    step(1);
    n_cmp++; if (out_din !== 24'hFF0000) begin n_bad++; $display("FAIL mid_held got=%h exp=ff0000", out_din); end
    reset = 1'b1;
    clear_obs();
    for (int i = 0; i < 12; i++) push_pair(24'h102030, 8'h05);
    #1;
    n_cmp++; if (img_rd_en !== 1'b0)  begin n_bad++; $display("FAIL mid_img_rd_en got=%b exp=0", img_rd_en); end
    n_cmp++; if (edge_rd_en !== 1'b0) begin n_bad++; $display("FAIL mid_edge_rd_en got=%b exp=0", edge_rd_en); end
    n_cmp++; if (out_wr_en !== 1'b0)  begin n_bad++; $display("FAIL mid_out_wr_en got=%b exp=0", out_wr_en); end
    n_cmp++; if (out_din !== 24'h0)   begin n_bad++; $display("FAIL mid_out_din got=%h exp=000000", out_din); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL mid_frame_done got=%b exp=0", frame_done); end
    out_full = 1'b0;
    step(2);
    reset = 1'b0;
    wait_cap(12, 60, "mid_frame");
    step(3);
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp_pix(i, 24'h102030, 8'h05, 0)) begin
        n_bad++; $display("FAIL mid_pix[%0d] got=%h exp=%h", i, cap[i], exp_pix(i, 24'h102030, 8'h05, 0));
      end
    end
    n_cmp++; if (cap.size() !== 12) begin n_bad++; $display("FAIL mid_write_count got=%0d exp=12", cap.size()); end
    n_cmp++; if (fd_cnt !== 1)      begin n_bad++; $display("FAIL mid_frame_done got=%0d exp=1", fd_cnt); end
    clear_obs();
  endtask

  task automatic test_threshold();
    logic [7:0] e;
    for (int i = 0; i < 12; i++) begin
      e = (i == 5) ? 8'd8 : (i == 6) ? 8'd9 : (i == 0) ? 8'd200 : 8'd0;
      edge8_q.push_back(e);
    end
    refresh();
    step(60);
    n_cmp++; if (cap8.size() !== 12) begin n_bad++; $display("FAIL thr_write_count got=%0d exp=12", cap8.size()); end
    for (int i = 0; i < 12 && i < cap8.size(); i++) begin
      e = (i == 5) ? 8'd8 : (i == 6) ? 8'd9 : (i == 0) ? 8'd200 : 8'd0;
      n_cmp++;
      if (cap8[i] !== exp_pix(i, 24'h102030, e, 8)) begin
        n_bad++; $display("FAIL thr_pix[%0d] got=%h exp=%h", i, cap8[i], exp_pix(i, 24'h102030, e, 8));
      end
    end
    n_cmp++; if (fd8_cnt !== 1) begin n_bad++; $display("FAIL thr_frame_done got=%0d exp=1", fd8_cnt); end
    clear_obs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) push_pair(24'h102030, 8'h05);
    wait_cap(24, 120, "b2b_writes");
    step(3);
    for (int i = 0; i < 24 && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp_pix(i, 24'h102030, 8'h05, 0)) begin
        n_bad++; $display("FAIL b2b_pix[%0d] got=%h exp=%h", i, cap[i], exp_pix(i, 24'h102030, 8'h05, 0));
      end
    end
    n_cmp++; if (cap.size() !== 24) begin n_bad++; $display("FAIL b2b_write_count got=%0d exp=24", cap.size()); end
    n_cmp++; if (fd_cnt !== 2)      begin n_bad++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_cnt); end
    n_cmp++; if (misaligned !== 0)  begin n_bad++; $display("FAIL pop_alignment got=%0d exp=0", misaligned); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; misaligned = 0;
    pend_img = 1'b0; pend_edge = 1'b0; pend8 = 1'b0;
    clear_obs();
    test_reset();
    test_frame();
    test_starve();
    test_stall();
    test_reset_mid();
    test_threshold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
